// File: rtl/wormhole_output_arbiter.sv
// Per-output switch allocator: round-robin on head flits, 1-cycle grant latency, wormhole lock until tail.
// Transfers are combinational (rd_en/out_wr_en) and blocked while out_ON_OFF=1.
module wormhole_output_arbiter #(
  parameter int PORTS   = 5,
  parameter int STALL_W = 8,
  parameter int PKT_W   = 16,
  localparam int IDX_W  = $clog2(PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PORTS-1:0]     req,
  input  logic [2*PORTS-1:0]   front_type,
  input  logic                 out_ON_OFF,
  output logic [PORTS-1:0]     grant,
  output logic [IDX_W-1:0]     out_sel,
  output logic [PORTS-1:0]     rd_en,
  output logic                 out_wr_en,
  output logic                 locked,
  output logic                 proto_err,
  output logic [STALL_W-1:0]   stall_cnt,
  output logic [PKT_W-1:0]     pkt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOCKED = 2'b01
  } state_t;

  state_t               r_state, w_nxt_state;
  logic [PORTS-1:0]     r_grant, w_nxt_grant;
  logic [IDX_W-1:0]     r_out_sel, w_nxt_sel;
  logic [IDX_W-1:0]     r_rr_ptr, w_nxt_rr;
  logic                 r_proto_err, w_nxt_perr;
  logic [STALL_W-1:0]   r_stall_cnt, w_nxt_stall;
  logic [PKT_W-1:0]     r_pkt_cnt, w_nxt_pkt;

  logic [IDX_W-1:0]     w_idx, w_pick;
  logic                 w_found, w_bad_idle;
  logic                 w_own_req, w_xfer;
  logic [1:0]           w_own_type;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
      r_proto_err <= 1'b0;
      r_stall_cnt <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_grant     <= w_nxt_grant;
      r_out_sel   <= w_nxt_sel;
      r_rr_ptr    <= w_nxt_rr;
      r_proto_err <= w_nxt_perr;
      r_stall_cnt <= w_nxt_stall;
      r_pkt_cnt   <= w_nxt_pkt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_sel   = r_out_sel;
    w_nxt_rr    = r_rr_ptr;
    w_nxt_perr  = r_proto_err;
    w_nxt_stall = r_stall_cnt;
    w_nxt_pkt   = r_pkt_cnt;
    rd_en       = '0;
    out_wr_en   = 1'b0;
    w_idx       = '0;
    w_pick      = '0;
    w_found     = 1'b0;
    w_bad_idle  = 1'b0;

    // Walk from the farthest candidate back to rr_ptr so the nearest eligible head wins.
    for (int k = PORTS - 1; k >= 0; k--) begin
      w_idx = IDX_W'((int'(r_rr_ptr) + k) % PORTS);
      if (req[w_idx] && front_type[{w_idx, 1'b1}]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
      if (req[w_idx] && !front_type[{w_idx, 1'b1}]) begin
        w_bad_idle = 1'b1;
      end
    end

    w_own_req  = req[r_out_sel];
    w_own_type = front_type[{r_out_sel, 1'b0} +: 2];
    w_xfer     = (r_state == S_LOCKED) && w_own_req && !out_ON_OFF && !rst;

    case (r_state)
      S_IDLE: begin
        w_nxt_stall = '0;
        if (w_bad_idle) w_nxt_perr = 1'b1;
        if (w_found) begin
          w_nxt_state = S_LOCKED;
          w_nxt_grant = PORTS'(1) << w_pick;
          w_nxt_sel   = w_pick;
        end
      end
      S_LOCKED: begin
        if (w_xfer) begin
          rd_en       = r_grant;
          out_wr_en   = 1'b1;
          w_nxt_stall = '0;
          if (w_own_type == 2'b10) w_nxt_perr = 1'b1;
          if (w_own_type[0]) begin
            w_nxt_state = S_IDLE;
            w_nxt_grant = '0;
            w_nxt_sel   = '0;
            w_nxt_rr    = (r_out_sel == IDX_W'(PORTS - 1)) ? '0 : r_out_sel + IDX_W'(1);
            w_nxt_pkt   = r_pkt_cnt + PKT_W'(1);
          end
        end else if (w_own_req && out_ON_OFF && (r_stall_cnt != {STALL_W{1'b1}})) begin
          w_nxt_stall = r_stall_cnt + STALL_W'(1);
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_grant = '0;
        w_nxt_sel   = '0;
        w_nxt_stall = '0;
      end
    endcase
  end

  assign grant     = r_grant;
  assign out_sel   = r_out_sel;
  assign locked    = (r_state == S_LOCKED);
  assign proto_err = r_proto_err;
  assign stall_cnt = r_stall_cnt;
  assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Bench for wormhole_output_arbiter: per-input flit queues feed the DUT; a packet-level reference model predicts every output.
module tb_wormhole_output_arbiter;
  localparam int P = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [P-1:0]   req;
  logic [2*P-1:0] front_type;
  logic           out_ON_OFF;
  logic [P-1:0]   grant;
  logic [2:0]     out_sel;
  logic [P-1:0]   rd_en;
  logic           out_wr_en;
  logic           locked;
  logic           proto_err;
  logic [7:0]     stall_cnt;
  logic [15:0]    pkt_cnt;

  always #5 clk = ~clk;

  wormhole_output_arbiter #(.PORTS(P), .STALL_W(8), .PKT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .front_type(front_type), .out_ON_OFF(out_ON_OFF),
    .grant(grant), .out_sel(out_sel), .rd_en(rd_en), .out_wr_en(out_wr_en),
    .locked(locked), .proto_err(proto_err), .stall_cnt(stall_cnt), .pkt_cnt(pkt_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] fq [P][256];
  int  wp [P];
  int  rp [P];
  bit  en [P];
  int  rd_seen [P];
  int  gl [64];
  int  gn = 0;
  logic [P-1:0] prev_g = '0;
  logic [P-1:0] last_rd;
  bit  chk_on = 0;

  // Reference model: packet-level state of the output
  bit  m_lock = 0;
  int  m_own = 0, m_rr = 0, m_stall = 0, m_pkt = 0;
  bit  m_perr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt(input int p);
    return wp[p] - rp[p];
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < P; i++) if (cnt(i) != 0) return 0;
    return 1;
  endfunction

  function automatic int oh_idx(input logic [P-1:0] g);
    for (int i = 0; i < P; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic push(input int p, input logic [1:0] t);
    fq[p][wp[p] % 256] = t;
    wp[p]++;
  endtask

  task automatic push_pkt(input int p, input int len);
    if (len == 1) push(p, 2'b11);
    else begin
      push(p, 2'b10);
      for (int j = 0; j < len - 2; j++) push(p, 2'b00);
      push(p, 2'b01);
    end
  endtask

  task automatic flush(input int p);
    rp[p] = wp[p];
  endtask

  task automatic step();
    logic [P-1:0] eg, erd;
    logic [2:0]   es;
    logic [1:0]   t;
    bit           xfer;
    int           pop_p;
    for (int i = 0; i < P; i++) begin
      req[i] = (cnt(i) > 0) && en[i];
      front_type[2*i +: 2] = (cnt(i) > 0) ? fq[i][rp[i] % 256] : 2'b00;
    end
    @(negedge clk);
    eg = '0;
    if (m_lock) eg[m_own] = 1'b1;
    es = m_lock ? 3'(m_own) : 3'd0;
    xfer = m_lock && req[m_own] && !out_ON_OFF && !rst;
    erd = '0;
    if (xfer) erd[m_own] = 1'b1;
    if (chk_on) begin
      chk("grant", 32'(grant), 32'(eg));
      chk("out_sel", 32'(out_sel), 32'(es));
      chk("rd_en", 32'(rd_en), 32'(erd));
      chk("out_wr_en", 32'(out_wr_en), 32'(xfer));
      chk("locked", 32'(locked), 32'(m_lock));
      chk("proto_err", 32'(proto_err), 32'(m_perr));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
    end
    last_rd = rd_en;
    for (int i = 0; i < P; i++) if (rd_en[i] === 1'b1) rd_seen[i]++;
    if (grant != '0 && prev_g == '0 && gn < 64) begin
      gl[gn] = oh_idx(grant);
      gn++;
    end
    prev_g = grant;
    pop_p = xfer ? m_own : -1;
    if (rst) begin
      m_lock = 0; m_own = 0; m_rr = 0; m_perr = 0; m_stall = 0; m_pkt = 0;
    end else if (!m_lock) begin
      for (int i = 0; i < P; i++)
        if (req[i] && !front_type[2*i+1]) m_perr = 1;
      for (int k = 0; k < P; k++) begin
        int i;
        i = (m_rr + k) % P;
        if (req[i] && front_type[2*i+1]) begin
          m_lock = 1; m_own = i;
          break;
        end
      end
      m_stall = 0;
    end else begin
      t = front_type[2*m_own +: 2];
      if (xfer) begin
        m_stall = 0;
        if (t == 2'b10) m_perr = 1;
        if (t[0]) begin
          m_lock = 0;
          m_rr = (m_own + 1) % P;
          m_pkt = (m_pkt + 1) % 65536;
        end
      end else if (req[m_own] && out_ON_OFF) begin
        m_stall = (m_stall < 255) ? m_stall + 1 : 255;
      end
    end
    if (pop_p >= 0) rp[pop_p]++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int n = 0;
    while (!all_empty() && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(all_empty()), 32'd1);
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, base, n;
    for (int i = 0; i < P; i++) begin
      wp[i] = 0; rp[i] = 0; en[i] = 1; rd_seen[i] = 0;
    end
    for (int i = 0; i < 64; i++) gl[i] = -1;
    rst = 1; out_ON_OFF = 0; req = '0; front_type = '0;

    // 1: two reset cycles, then idle
    step();
    chk_on = 1;
    step();
    rst = 0;
    step();
    step();

    // 2: 4-flit packet on input 2
    push_pkt(2, 4);
    repeat (8) step();
    chk("t2_rd_pulses", 32'(rd_seen[2]), 32'd4);
    chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("t2_idle", 32'(locked), 32'd0);

    // 3: single-flit packets on 0,1,3 from rr_ptr=0, then rr_ptr must be 4
    rst = 1; step(); rst = 0;
    g0 = gn;
    push_pkt(0, 1); push_pkt(1, 1); push_pkt(3, 1);
    run_until_empty(30, "t3_drain");
    chk("t3_order0", 32'(gl[g0]), 32'd0);
    chk("t3_order1", 32'(gl[g0+1]), 32'd1);
    chk("t3_order2", 32'(gl[g0+2]), 32'd3);
    push_pkt(0, 1); push_pkt(4, 1);
    run_until_empty(30, "t3_rr_drain");
    chk("t3_rr4", 32'(gl[g0+3]), 32'd4);

    // 4: locked on input 4 with downstream full for 300 cycles
    base = rd_seen[4];
    push_pkt(4, 2);
    out_ON_OFF = 1;
    repeat (302) step();
    chk("t4_no_rd", 32'(rd_seen[4] - base), 32'd0);
    chk("t4_sat", 32'(stall_cnt), 32'd255);
    out_ON_OFF = 0;
    step();
    chk("t4_clear", 32'(stall_cnt), 32'd0);
    run_until_empty(10, "t4_drain");

    // 5: stray body flit on input 1 while idle
    push(1, 2'b00);
    repeat (3) step();
    chk("t5_perr", 32'(proto_err), 32'd1);
    chk("t5_nogrant", 32'(grant), 32'd0);
    g0 = gn;
    push_pkt(3, 2);
    repeat (6) step();
    chk("t5_served3", 32'(gl[g0]), 32'd3);
    chk("t5_sticky", 32'(proto_err), 32'd1);
    flush(1);
    step();

    // 6: reset in the middle of a packet
    rst = 1; step(); rst = 0;
    base = rd_seen[2];
    push_pkt(2, 4);
    n = 0;
    while (rd_seen[2] - base < 2 && n < 10) begin
      step();
      n++;
    end
    chk("t6_two_flits", 32'(rd_seen[2] - base), 32'd2);
    rst = 1;
    step();
    chk("t6_rd_in_rst", 32'(last_rd), 32'd0);
    rst = 0;
    flush(2);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_locked", 32'(locked), 32'd0);
    g0 = gn;
    push_pkt(4, 1); push_pkt(0, 1);
    run_until_empty(20, "t6_drain");
    chk("t6_rr0_first", 32'(gl[g0]), 32'd0);
    chk("t6_rr0_second", 32'(gl[g0+1]), 32'd4);

    // Random traffic with bubbles, backpressure and occasional reset
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < P; i++) begin
        if (cnt(i) < 8 && $urandom_range(0, 3) == 0) push_pkt(i, int'($urandom_range(1, 4)));
        en[i] = ($urandom_range(0, 3) != 0);
      end
      out_ON_OFF = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        for (int i = 0; i < P; i++) flush(i);
      end else begin
        rst = 0;
      end
      step();
    end
    rst = 0;
    out_ON_OFF = 0;
    for (int i = 0; i < P; i++) en[i] = 1;
    run_until_empty(600, "rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
